// File: rtl/pdm_multichannel.sv
// Multi-channel first-order PDM with per-channel shadow/target registers and atomic commit.
// Define PDM_RAMP_EN to compile in a one-LSB-per-cycle slew limit between target levels.
module pdm_multichannel #(
    parameter int CHANNELS = 4,
    parameter int BITS     = 8,
    localparam int AW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stb,
    input  logic [AW-1:0]       addr,
    input  logic [BITS-1:0]     data,
    input  logic                commit,
    output logic                busy,
    output logic [CHANNELS-1:0] pdm
);

    // Bus side: stb and commit are single-cycle qualifiers sampled on every rising
    // edge with no back-pressure; a write and a commit in the same cycle act as
    // write-then-commit, so the committed target already holds the new data.
    logic [CHANNELS-1:0][BITS-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0][BITS-1:0] target_q, target_d;
    logic [CHANNELS-1:0][BITS-1:0] level_q,  level_d;
    logic [CHANNELS-1:0][BITS:0]   acc_q,    acc_d;
    logic [CHANNELS-1:0]           differ;

    always_comb begin
        shadow_d = shadow_q;
        if (stb && (int'(addr) < CHANNELS)) begin
            shadow_d[addr] = data;
        end
    end

    always_comb begin
        target_d = target_q;
        if (commit) begin
            target_d = shadow_d;
        end
    end

`ifdef PDM_RAMP_EN
    // Step from the current level so a retarget mid-ramp never overshoots.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (level_q[i] < target_q[i]) begin
                level_d[i] = level_q[i] + 1'b1;
            end else if (level_q[i] > target_q[i]) begin
                level_d[i] = level_q[i] - 1'b1;
            end
        end
    end
`else
    always_comb begin
        level_d = target_q;
    end
`endif

    // Carry out of the accumulator is the PDM bit; the carry is dropped before the
    // next add so phase carries over level changes.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < CHANNELS; i++) begin
            acc_d[i] = {1'b0, acc_q[i][BITS-1:0]} + {1'b0, level_q[i]};
        end
    end

    always_comb begin
        differ = '0;
        pdm    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            differ[i] = (level_q[i] != target_q[i]);
            pdm[i]    = acc_q[i][BITS];
        end
    end

    assign busy = |differ;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            target_q <= '0;
            level_q  <= '0;
            acc_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            target_q <= target_d;
            level_q  <= level_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: tb/tb_pdm_multichannel.sv
// Scoreboard bench for pdm_multichannel: a 4-channel instance and a 3-channel
// instance for out-of-range addressing; expected {busy,pdm} pushed per cycle.
module tb_pdm_multichannel;

    localparam int BITS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       stb, commit;
    logic [1:0] addr;
    logic [7:0] data;
    logic       busy;
    logic [3:0] pdm;

    logic       stb3, commit3;
    logic [1:0] addr3;
    logic [7:0] data3;
    logic       busy3;
    logic [2:0] pdm3;

    int checks   = 0;
    int failures = 0;
    string cur_test = "init";

    logic [4:0] exp_q[$];
    logic [3:0] exp3_q[$];

    pdm_multichannel #(.CHANNELS(4), .BITS(BITS)) dut (
        .clk(clk), .rst(rst), .stb(stb), .addr(addr), .data(data),
        .commit(commit), .busy(busy), .pdm(pdm)
    );

    pdm_multichannel #(.CHANNELS(3), .BITS(BITS)) dut3 (
        .clk(clk), .rst(rst), .stb(stb3), .addr(addr3), .data(data3),
        .commit(commit3), .busy(busy3), .pdm(pdm3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: compares one expected entry per cycle, away from the rising edge.
    always @(negedge clk) begin
        logic [4:0] e;
        logic [3:0] e3;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({busy, pdm} !== e) begin
                failures++;
                $display("FAIL %s main {busy,pdm}: got %b required %b", cur_test, {busy, pdm}, e);
            end
        end
        if (exp3_q.size() > 0) begin
            e3 = exp3_q.pop_front();
            checks++;
            if ({busy3, pdm3} !== e3) begin
                failures++;
                $display("FAIL %s ch3dut {busy,pdm}: got %b required %b", cur_test, {busy3, pdm3}, e3);
            end
        end
    end

    // Closed-form density: bit produced by the k-th accumulation of a constant level from phase 0.
    function automatic logic pbit(input int lvl, input int k);
        return ((k * lvl) / 256) != (((k - 1) * lvl) / 256);
    endfunction

    task automatic tick(input bit c1, input logic [4:0] e1, input bit c3, input logic [3:0] e3);
        @(posedge clk);
        #1;
        if (c1) exp_q.push_back(e1);
        if (c3) exp3_q.push_back(e3);
    endtask

    task automatic t1(input logic [4:0] e1);
        tick(1'b1, e1, 1'b1, 4'b0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        t1(5'b0);
        rst = 1'b0;
    endtask

    task automatic check_eq(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    initial begin
        int ones1, ones2, ones3;
        rst = 1'b1; stb = 1'b1; commit = 1'b1; addr = 2'd0; data = 8'hFF;
        stb3 = 1'b1; commit3 = 1'b1; addr3 = 2'd0; data3 = 8'hFF;

        cur_test = "reset_hold";
        repeat (3) t1(5'b0);
        rst = 1'b0; stb = 1'b0; commit = 1'b0;
        stb3 = 1'b0; commit3 = 1'b0;
        cur_test = "reset_release";
        repeat (16) t1(5'b0);

        cur_test = "ch0_128";
        do_reset();
        stb = 1'b1; addr = 2'd0; data = 8'd128;
        t1(5'b0);
        stb = 1'b0; commit = 1'b1;
        t1(5'b1_0000);
        commit = 1'b0;
        t1(5'b0);
        for (int k = 1; k <= 8; k++) begin
            t1({4'b0000, (k % 2 == 0)});
        end

        cur_test = "multi_commit";
        do_reset();
        stb = 1'b1; addr = 2'd1; data = 8'd64;  t1(5'b0);
        addr = 2'd2; data = 8'd255;             t1(5'b0);
        addr = 2'd3; data = 8'd0;               t1(5'b0);
        stb = 1'b0; commit = 1'b1;
        t1(5'b1_0000);
        commit = 1'b0;
        t1(5'b0);
        ones1 = 0; ones2 = 0; ones3 = 0;
        for (int k = 1; k <= 256; k++) begin
            t1({1'b0, 1'b0, pbit(255, k), pbit(64, k), 1'b0});
            ones1 += int'(pdm[1]);
            ones2 += int'(pdm[2]);
            ones3 += int'(pdm[3]);
        end
        check_eq("ones_ch1", ones1, 64);
        check_eq("ones_ch2", ones2, 255);
        check_eq("ones_ch3", ones3, 0);

        cur_test = "write_through";
        do_reset();
        stb = 1'b1; commit = 1'b1; addr = 2'd0; data = 8'd32;
        t1(5'b1_0000);
        stb = 1'b0; commit = 1'b0;
        t1(5'b0);
        for (int k = 1; k <= 16; k++) begin
            t1({4'b0000, pbit(32, k)});
        end

        cur_test = "addr_out_of_range";
        do_reset();
        stb3 = 1'b1; commit3 = 1'b1; addr3 = 2'd3; data3 = 8'd200;
        tick(1'b1, 5'b0, 1'b1, 4'b0000);
        stb3 = 1'b0; commit3 = 1'b0;
        repeat (8) tick(1'b1, 5'b0, 1'b1, 4'b0000);
        cur_test = "ch2_of_3";
        stb3 = 1'b1; commit3 = 1'b1; addr3 = 2'd2; data3 = 8'd128;
        tick(1'b1, 5'b0, 1'b1, 4'b1000);
        stb3 = 1'b0; commit3 = 1'b0;
        tick(1'b1, 5'b0, 1'b1, 4'b0000);
        for (int k = 1; k <= 6; k++) begin
            tick(1'b1, 5'b0, 1'b1, {1'b0, pbit(128, k), 2'b00});
        end

`ifdef PDM_RAMP_EN
        cur_test = "ramp_retarget";
        do_reset();
        stb = 1'b1; addr = 2'd0; data = 8'd4;
        t1(5'b0);
        stb = 1'b0; commit = 1'b1;
        t1(5'b1_0000);
        commit = 1'b0; stb = 1'b1; data = 8'd2;
        t1(5'b1_0000);
        stb = 1'b0;
        t1(5'b1_0000);
        commit = 1'b1;
        t1(5'b1_0000);
        commit = 1'b0;
        repeat (8) t1(5'b0);

        cur_test = "ramp_reset";
        do_reset();
        stb = 1'b1; commit = 1'b1; addr = 2'd0; data = 8'd200;
        t1(5'b1_0000);
        stb = 1'b0; commit = 1'b0;
        repeat (100) tick(1'b0, 5'b0, 1'b1, 4'b0000);
        check_eq("ramp_busy_mid", int'(busy), 1);
        rst = 1'b1;
        t1(5'b0);
        rst = 1'b0;
        repeat (6) t1(5'b0);
`endif

        cur_test = "drain";
        @(negedge clk);
        #1;
        check_eq("queue_drained", exp_q.size() + exp3_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pdm_multichannel.md
# pdm_multichannel

Multi-channel first-order pulse-density modulator for audio/LED/DAC outputs behind a Wishbone peripheral. It generalises the single-channel PDM stage: it supports CHANNELS independent modulators of BITS resolution and per-channel shadow registers. A global commit updates all channels atomically, and an optional slew-limited ramp between levels can be compiled in. The block sits between the bus-facing register decoder and the output pins.

## Interface
- CHANNELS, 4: number of modulator channels (≥1).
- BITS, 8: level resolution per channel (≥2).
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- stb  in  1  write strobe; loads `data` into shadow register `addr`.
- addr  in  max(1,$clog2(CHANNELS))  shadow register index.
- data  in  BITS  level value, unsigned.
- commit  in  1  copies all shadow registers to channel targets.
- busy  out  1  high while any channel level differs from its target.
- pdm  out  CHANNELS  one PDM bitstream per channel, registered.

## Operation
- Per-channel state:
  - shadow[i] (BITS)
  - target[i] (BITS)
  - level[i] (BITS)
  - acc[i] (BITS+1)
- Shadow write: on a clock edge with stb=1 and addr<CHANNELS, shadow[addr] <= data. Writes with addr≥CHANNELS are ignored; no state changes.
- Commit: on a clock edge with commit=1, target[i] <= shadow[i] for all i. If stb and commit occur in the same cycle, commit uses the newly written data for the addressed channel (write-through).
- Modulator, every cycle, all channels: acc[i] <= acc[i][BITS-1:0] + level[i]. pdm[i] = acc[i][BITS]. Density of ones = level/2^BITS.
  - level 0: pdm constant 0.
  - level 2^BITS-1: one 0 per 2^BITS cycles.
- Level update (ramp disabled): level[i] follows target[i], so level[i] <= target[i] every cycle.
- Reset: shadow, target, level and acc are cleared to 0 in all channels. pdm=0, busy=0. Reset overrides stb/commit in the same cycle. Reset mid-ramp abandons the ramp immediately.

## Timing
- stb at edge n: shadow valid after edge n.
- commit at edge m: target updated at edge m, level at edge m+1.
  - First accumulation with the new level happens at edge m+2.
  - pdm first reflects the new level after edge m+2.
  - Commit-to-first-affected-output latency is 2 cycles.
- busy is combinational from level≠target, ORed over channels.
  - Ramp disabled: busy is high for exactly 1 cycle after a changing commit (edge m to edge m+1).
- Accumulators are never cleared by commit; phase is continuous across level changes.

## Configuration
- PDM_RAMP_EN defined:
  - Each cycle, each level[i] steps one LSB toward target[i]: +1 if below, −1 if above, hold if equal.
  - A change of Δ takes |Δ| cycles.
  - busy stays high until all channels reach their targets.
  - A new commit mid-ramp retargets from the current level.
  - There is no overshoot and no wrap at 0 or 2^BITS-1.
- PDM_RAMP_EN undefined: level[i] <= target[i] as above. Ramp logic is absent.

## Test plan
- Reset: hold rst 3 cycles with stb=1, commit=1, data=8'hFF -> pdm=0, busy=0, and all channels remain 0 for 16 cycles after release.
- BITS=8, write ch0=128, commit -> after 2 cycles pdm[0] alternates 0,1 (period 2). Other channels stay 0.
- Write ch1=64, ch2=255, ch3=0, single commit -> over 256 cycles, pdm[1] has 64 ones, pdm[2] has 255, pdm[3] has 0. All three start in the same cycle.
- stb addr=ch0 data=32 with commit in the same cycle -> target[0]=32. Write with addr=CHANNELS (CHANNELS non-power-of-2 build, e.g. 3) -> no channel changes.
- PDM_RAMP_EN: commit ch0 0→4 -> level 1,2,3,4 on successive cycles, busy high 4 cycles. Recommit to 2 at level 3 -> level 2, then hold.
- PDM_RAMP_EN: rst asserted mid-ramp (level 100 toward 200) -> next cycle level=0, target=0, busy=0, pdm=0.
